demux1x2_stream: RTL and testbench

DEMUX1X2_STREAM -- requirements
Module: demux1x2_stream

---
 rtl/demux1x2_stream.sv | 100 ++++++++++
 tb/tb_demux1x2_stream.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/demux1x2_stream.sv
// 1-to-2 stream demultiplexer with a one-entry output register per channel.
// Optional DEMUX_DROP_CNT_EN adds a saturating count of beats discarded while en=0.

module demux1x2_stream_ch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  // A load wins over a drain, so drain+load in one cycle keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (ready) begin
      valid <= 1'b0;
    end
  end

endmodule

module demux1x2_stream #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic             sel,
  input  logic             en,
  output logic [WIDTH-1:0] m0_data,
  output logic             m0_valid,
  input  logic             m0_ready,
  output logic [WIDTH-1:0] m1_data,
  output logic             m1_valid,
  input  logic             m1_ready
`ifdef DEMUX_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0][WIDTH-1:0] ch_data;
  logic [NUM_CH-1:0]            ch_valid;
  logic [NUM_CH-1:0]            ch_ready;
  logic [NUM_CH-1:0]            ch_load;
  logic [NUM_CH-1:0]            ch_free;
  logic                         accept;

  assign ch_ready = {m1_ready, m0_ready};

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      assign ch_free[i] = !ch_valid[i] || ch_ready[i];
      assign ch_load[i] = accept && (sel == i[0]);

      demux1x2_stream_ch #(.WIDTH(WIDTH)) u_ch (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (ch_load[i]),
        .load_data (s_data),
        .ready     (ch_ready[i]),
        .data      (ch_data[i]),
        .valid     (ch_valid[i])
      );
    end
  endgenerate

  // With en low the beat is swallowed, so upstream never stalls.
  assign s_ready = !en || ch_free[sel];
  assign accept  = s_valid && en && ch_free[sel];

  assign m0_data  = ch_data[0];
  assign m0_valid = ch_valid[0];
  assign m1_data  = ch_data[1];
  assign m1_valid = ch_valid[1];

`ifdef DEMUX_DROP_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      drop_cnt <= 8'd0;
    else if (s_valid && !en && drop_cnt != 8'hFF)
      drop_cnt <= drop_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_demux1x2_stream.sv
// Scoreboard bench for demux1x2_stream: directed beats push expectations, a monitor pops on each output handshake.
module tb_demux1x2_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] s_data;
  logic       s_valid, s_ready, sel, en;
  logic [7:0] m0_data, m1_data;
  logic       m0_valid, m0_ready, m1_valid, m1_ready;
`ifdef DEMUX_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];

  always #5 clk = ~clk;

  demux1x2_stream #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .sel      (sel),
    .en       (en),
    .m0_data  (m0_data),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .m1_data  (m1_data),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready)
`ifdef DEMUX_DROP_CNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a handshake seen at the negedge completes on the next posedge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (m0_valid && m0_ready) begin
          if (exp0.size() == 0) chk("m0_unexpected_beat", {24'd0, m0_data}, 32'hFFFF_FFFF);
          else chk("m0_scoreboard", {24'd0, m0_data}, {24'd0, exp0.pop_front()});
        end
        if (m1_valid && m1_ready) begin
          if (exp1.size() == 0) chk("m1_unexpected_beat", {24'd0, m1_data}, 32'hFFFF_FFFF);
          else chk("m1_scoreboard", {24'd0, m1_data}, {24'd0, exp1.pop_front()});
        end
      end
    end
  end

  // Offer one beat; bounded wait for s_ready, then record the expectation.
  task automatic send(input logic ch, input logic [7:0] d);
    bit done = 0;
    s_valid = 1'b1; sel = ch; s_data = d;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (s_ready) begin
        if (ch) exp1.push_back(d); else exp0.push_back(d);
        done = 1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    s_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] vec [3];
    vec[0] = 8'h01; vec[1] = 8'h02; vec[2] = 8'h03;
    rst_n = 1'b0; s_data = 8'h00; s_valid = 1'b0; sel = 1'b0; en = 1'b1;
    m0_ready = 1'b1; m1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_m0_valid", {31'd0, m0_valid}, 32'd0);
    chk("rst_m1_valid", {31'd0, m1_valid}, 32'd0);
    chk("rst_m0_data", {24'd0, m0_data}, 32'd0);
    chk("rst_m1_data", {24'd0, m1_data}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
`ifdef DEMUX_DROP_CNT_EN
    chk("rst_drop_cnt", {24'd0, drop_cnt}, 32'd0);
`endif
    @(posedge clk); #1; rst_n = 1'b1;
    @(posedge clk); #1;

    // Single beat to channel 0.
    send(1'b0, 8'hA5);
    chk("a5_m0_valid", {31'd0, m0_valid}, 32'd1);
    chk("a5_m0_data", {24'd0, m0_data}, 32'hA5);
    chk("a5_m1_valid", {31'd0, m1_valid}, 32'd0);
    @(posedge clk); #1;
    chk("a5_m0_drained", {31'd0, m0_valid}, 32'd0);

    // Channel 1 stall and backpressure.
    m1_ready = 1'b0;
    send(1'b1, 8'h3C);
    s_valid = 1'b1; sel = 1'b1; s_data = 8'h77;
    repeat (3) begin
      @(negedge clk);
      chk("stall_s_ready", {31'd0, s_ready}, 32'd0);
      chk("stall_m1_data", {24'd0, m1_data}, 32'h3C);
      chk("stall_m1_valid", {31'd0, m1_valid}, 32'd1);
    end
    @(posedge clk); #1; m1_ready = 1'b1;
    @(negedge clk);
    chk("unstall_s_ready", {31'd0, s_ready}, 32'd1);
    exp1.push_back(8'h77);
    @(posedge clk); #1; s_valid = 1'b0;
    chk("drain_load_m1_valid", {31'd0, m1_valid}, 32'd1);
    chk("drain_load_m1_data", {24'd0, m1_data}, 32'h77);
    @(posedge clk); #1;

    // Back-to-back beats, no bubble.
    s_valid = 1'b1; sel = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_data = vec[i];
      @(negedge clk);
      chk("b2b_s_ready", {31'd0, s_ready}, 32'd1);
      exp0.push_back(vec[i]);
      @(posedge clk); #1;
      chk("b2b_m0_valid", {31'd0, m0_valid}, 32'd1);
      chk("b2b_m0_data", {24'd0, m0_data}, {24'd0, vec[i]});
    end
    s_valid = 1'b0;
    @(posedge clk); #1;
    chk("b2b_m0_drained", {31'd0, m0_valid}, 32'd0);

    // Channel 0 stalled full; channel 1 still accepts.
    m0_ready = 1'b0; m1_ready = 1'b0;
    send(1'b0, 8'hC3);
    send(1'b1, 8'h5A);
    chk("ind_m1_data", {24'd0, m1_data}, 32'h5A);
    chk("ind_m1_valid", {31'd0, m1_valid}, 32'd1);
    chk("ind_m0_data", {24'd0, m0_data}, 32'hC3);
    chk("ind_m0_valid", {31'd0, m0_valid}, 32'd1);

    // Discard with en=0 while both full: registers untouched, s_ready=1.
    en = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 300; i++) begin
      sel = i[0]; s_data = i[7:0];
      @(negedge clk);
      if (i % 50 == 0) begin
        chk("drop_s_ready", {31'd0, s_ready}, 32'd1);
        chk("drop_hold_m0", {24'd0, m0_data}, 32'hC3);
        chk("drop_hold_m1", {24'd0, m1_data}, 32'h5A);
      end
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
`ifdef DEMUX_DROP_CNT_EN
    chk("drop_cnt_sat", {24'd0, drop_cnt}, 32'd255);
`endif
    chk("drop_end_m0_valid", {31'd0, m0_valid}, 32'd1);
    chk("drop_end_m1_valid", {31'd0, m1_valid}, 32'd1);

    // Asynchronous reset mid-cycle with both channels full.
    #2; rst_n = 1'b0; #1;
    chk("async_m0_valid", {31'd0, m0_valid}, 32'd0);
    chk("async_m1_valid", {31'd0, m1_valid}, 32'd0);
    chk("async_m0_data", {24'd0, m0_data}, 32'd0);
    chk("async_m1_data", {24'd0, m1_data}, 32'd0);
    chk("async_s_ready", {31'd0, s_ready}, 32'd1);
    exp0.delete(); exp1.delete();
    @(posedge clk); #1; rst_n = 1'b1;

    // Discard with empty channels: count 20 edges, no outputs.
    en = 1'b0; s_valid = 1'b1; sel = 1'b1;
    repeat (20) @(posedge clk);
    #1; s_valid = 1'b0;
    chk("drop_empty_m0_valid", {31'd0, m0_valid}, 32'd0);
    chk("drop_empty_m1_valid", {31'd0, m1_valid}, 32'd0);
`ifdef DEMUX_DROP_CNT_EN
    chk("drop_cnt_20", {24'd0, drop_cnt}, 32'd20);
`endif

    // First acceptance after reset.
    en = 1'b1; m0_ready = 1'b1; m1_ready = 1'b1;
    send(1'b1, 8'h99);
    chk("post_rst_m1_data", {24'd0, m1_data}, 32'h99);
    chk("post_rst_m0_valid", {31'd0, m0_valid}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty0", exp0.size(), 32'd0);
    chk("sb_empty1", exp1.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
